rc5_key_schedule: RTL and testbench

Parametrised RC5 key-schedule engine for the RC5 datapath. It initialises the S table in an external RAM with S[i] = P + i·Q, one write per cycle. When built with mixing, it then runs the standard 3·max(T,C) mixing pass over S and the key-word RAM L. The block sits between the key loader, which fills L, and the encrypt/decrypt rounds, which read S once oDone is high.

---
 rtl/rc5_key_schedule.sv | 257 +++++++++++++++++++++++++
 tb/tb_rc5_key_schedule.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_key_schedule.sv
// rc5_key_schedule
// Fills the RC5 S table in an external RAM with S[i] = P + i*Q, one write per
// cycle. Build option S_MIX_EN adds the 3*max(T,C) key-mixing pass over S and L;
// without it INIT goes straight to DONE and the L port is tied to zero.
// Every RAM-facing output comes from a flop: the *_d side of an output flop is
// the access (address/data/enable) presented during the following cycle.
module rc5_key_schedule #(
   parameter int           W  = 32,
   parameter int           T  = 26,
   parameter int           C  = 4,
   parameter logic [W-1:0] PW = 32'hB7E15163,
   parameter logic [W-1:0] QW = 32'h9E3779B9,
   localparam int          T_LENGTH = $clog2(T),
   localparam int          C_LENGTH = ($clog2(C) > 1) ? $clog2(C) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iStart,
   output logic                oBusy,
   output logic                oDone,
   output logic [T_LENGTH-1:0] oS_address,
   output logic [W-1:0]        oS_sub_i_prima,
   output logic                oS_we,
   input  logic [W-1:0]        iS_sub_i,
   output logic [C_LENGTH-1:0] oL_address,
   output logic [W-1:0]        oL_data,
   output logic                oL_we,
   input  logic [W-1:0]        iL_data
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_INIT     = 3'd1;
   localparam logic [2:0] ST_DONE     = 3'd6;

   logic [2:0]          state_q,  state_d;
   logic [T_LENGTH-1:0] i_q,      i_d;
   logic [W-1:0]        acc_q,    acc_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;
   logic [T_LENGTH-1:0] s_addr_q, s_addr_d;
   logic [W-1:0]        s_data_q, s_data_d;
   logic                s_we_q,   s_we_d;

`ifdef S_MIX_EN
   localparam logic [2:0] ST_MIX_RD   = 3'd2;
   localparam logic [2:0] ST_MIX_WAIT = 3'd3;
   localparam logic [2:0] ST_MIX_A    = 3'd4;
   localparam logic [2:0] ST_MIX_B    = 3'd5;
   localparam int N   = 3 * ((T > C) ? T : C);
   localparam int RW  = $clog2(W);
   localparam int K_W = $clog2(N + 1);

   logic [C_LENGTH-1:0] j_q,      j_d;
   logic [K_W-1:0]      k_q,      k_d;
   logic [W-1:0]        a_q,      a_d;
   logic [W-1:0]        b_q,      b_d;
   logic [W-1:0]        l_q,      l_d;
   logic [C_LENGTH-1:0] l_addr_q, l_addr_d;
   logic [W-1:0]        l_data_q, l_data_d;
   logic                l_we_q,   l_we_d;
   logic [W-1:0]        a_new_s;
   logic [W-1:0]        b_new_s;
   logic [RW-1:0]       b_rot_s;

   // circular left rotate over W bits; amount 0 returns the operand
   function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] amt);
      logic [2*W-1:0] dbl;
      dbl = {x, x} << amt;
      return dbl[2*W-1:W];
   endfunction

   // mixing datapath: A from the S word arriving now, B from the latched L word and the new A
   always_comb begin
      a_new_s = rotl(iS_sub_i + a_q + b_q, RW'(32'd3));
      b_rot_s = a_q[RW-1:0] + b_q[RW-1:0];
      b_new_s = rotl(l_q + a_q + b_q, b_rot_s);
   end
`endif

   // next-state, counters and next RAM access
   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      done_d   = done_q;
      s_addr_d = s_addr_q;
      s_data_d = s_data_q;
      s_we_d   = 1'b0;
`ifdef S_MIX_EN
      j_d      = j_q;
      k_d      = k_q;
      a_d      = a_q;
      b_d      = b_q;
      l_d      = l_q;
      l_addr_d = l_addr_q;
      l_data_d = l_data_q;
      l_we_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (iStart) begin
               state_d  = ST_INIT;
               i_d      = {T_LENGTH{1'b0}};
               acc_d    = PW + QW;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               s_addr_d = {T_LENGTH{1'b0}};
               s_data_d = PW;
               s_we_d   = 1'b1;
`ifdef S_MIX_EN
               j_d      = {C_LENGTH{1'b0}};
               k_d      = {K_W{1'b0}};
               a_d      = {W{1'b0}};
               b_d      = {W{1'b0}};
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_INIT: begin
            if (i_q == T_LENGTH'(T - 1)) begin
               i_d      = {T_LENGTH{1'b0}};
               s_addr_d = {T_LENGTH{1'b0}};
`ifdef S_MIX_EN
               state_d  = ST_MIX_RD;
               l_addr_d = {C_LENGTH{1'b0}};
`else
               state_d  = ST_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
`endif
            end else begin
               i_d      = i_q + T_LENGTH'(1);
               s_we_d   = 1'b1;
               s_addr_d = i_q + T_LENGTH'(1);
               s_data_d = acc_q;
               acc_d    = acc_q + QW;
            end
         end
`ifdef S_MIX_EN
         ST_MIX_RD: begin
            state_d = ST_MIX_WAIT;
         end
         ST_MIX_WAIT: begin
            // read data is valid now; the S[i] write of the new A goes out next cycle
            state_d  = ST_MIX_A;
            a_d      = a_new_s;
            l_d      = iL_data;
            s_we_d   = 1'b1;
            s_data_d = a_new_s;
         end
         ST_MIX_A: begin
            state_d  = ST_MIX_B;
            b_d      = b_new_s;
            l_we_d   = 1'b1;
            l_addr_d = j_q;
            l_data_d = b_new_s;
         end
         ST_MIX_B: begin
            if (i_q == T_LENGTH'(T - 1)) begin
               i_d = {T_LENGTH{1'b0}};
            end else begin
               i_d = i_q + T_LENGTH'(1);
            end
            if (j_q == C_LENGTH'(C - 1)) begin
               j_d = {C_LENGTH{1'b0}};
            end else begin
               j_d = j_q + C_LENGTH'(1);
            end
            k_d      = k_q + K_W'(1);
            s_addr_d = i_d;
            l_addr_d = j_d;
            if (k_q == K_W'(N - 1)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = ST_MIX_RD;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // control and S-side output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         i_q      <= {T_LENGTH{1'b0}};
         acc_q    <= {W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         s_addr_q <= {T_LENGTH{1'b0}};
         s_data_q <= {W{1'b0}};
         s_we_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         s_addr_q <= s_addr_d;
         s_data_q <= s_data_d;
         s_we_q   <= s_we_d;
      end
   end

   assign oBusy          = busy_q;
   assign oDone          = done_q;
   assign oS_address     = s_addr_q;
   assign oS_sub_i_prima = s_data_q;
   assign oS_we          = s_we_q;

`ifdef S_MIX_EN
   // mixing registers and L-side output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         j_q      <= {C_LENGTH{1'b0}};
         k_q      <= {K_W{1'b0}};
         a_q      <= {W{1'b0}};
         b_q      <= {W{1'b0}};
         l_q      <= {W{1'b0}};
         l_addr_q <= {C_LENGTH{1'b0}};
         l_data_q <= {W{1'b0}};
         l_we_q   <= 1'b0;
      end else begin
         j_q      <= j_d;
         k_q      <= k_d;
         a_q      <= a_d;
         b_q      <= b_d;
         l_q      <= l_d;
         l_addr_q <= l_addr_d;
         l_data_q <= l_data_d;
         l_we_q   <= l_we_d;
      end
   end

   assign oL_address = l_addr_q;
   assign oL_data    = l_data_q;
   assign oL_we      = l_we_q;
`else
   // read ports are not needed without mixing
   logic unused_inputs_s;
   assign unused_inputs_s = &{1'b0, iS_sub_i, iL_data};

   assign oL_address = {C_LENGTH{1'b0}};
   assign oL_data    = {W{1'b0}};
   assign oL_we      = 1'b0;
`endif

endmodule

// File: tb/tb_rc5_key_schedule.sv
// tb_rc5_key_schedule
// Scoreboard bench: a reference model of the schedule pushes every expected S/L
// write when a run is started; a monitor pops and compares each DUT write.
// Honours S_MIX_EN the same way as the design.
module tb_rc5_key_schedule;

   typedef struct packed {
      logic [7:0]  addr;
      logic [63:0] data;
   } wr_t;

`ifdef S_MIX_EN
   localparam bit MIX = 1'b1;
`else
   localparam bit MIX = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // W=32 engine
   logic        start0 = 1'b0;
   logic        busy0, done0, s_we0, l_we0;
   logic [4:0]  s_addr0;
   logic [1:0]  l_addr0;
   logic [31:0] s_data0, l_data0, s_rd0, l_rd0;
   logic [31:0] s_mem0 [0:31];
   logic [31:0] l_mem0 [0:3];

   // W=16 engine
   logic        start1 = 1'b0;
   logic        busy1, done1, s_we1, l_we1;
   logic [4:0]  s_addr1;
   logic [0:0]  l_addr1;
   logic [15:0] s_data1, l_data1, s_rd1, l_rd1;
   logic [15:0] s_mem1 [0:31];
   logic [15:0] l_mem1 [0:1];

   int          check_cnt = 0;
   int          fail_cnt  = 0;
   bit          sel = 1'b0;
   bit          load_l = 1'b0;
   logic [63:0] key_l [0:3];
   logic [63:0] s_model [0:31];
   wr_t         s_exp[$];
   wr_t         l_exp[$];
   logic [63:0] s_log[$];
   logic [63:0] l_log[$];
   int          s_wr_cnt = 0;
   int          l_wr_cnt = 0;

   rc5_key_schedule dut (
      .clk(clk), .rst(rst), .iStart(start0), .oBusy(busy0), .oDone(done0),
      .oS_address(s_addr0), .oS_sub_i_prima(s_data0), .oS_we(s_we0), .iS_sub_i(s_rd0),
      .oL_address(l_addr0), .oL_data(l_data0), .oL_we(l_we0), .iL_data(l_rd0)
   );

   rc5_key_schedule #(.W(16), .T(18), .C(2), .PW(16'hB7E1), .QW(16'h9E37)) dut16 (
      .clk(clk), .rst(rst), .iStart(start1), .oBusy(busy1), .oDone(done1),
      .oS_address(s_addr1), .oS_sub_i_prima(s_data1), .oS_we(s_we1), .iS_sub_i(s_rd1),
      .oL_address(l_addr1), .oL_data(l_data1), .oL_we(l_we1), .iL_data(l_rd1)
   );

   // external S and L RAMs with one-cycle synchronous read; L preloadable from key_l
   always @(posedge clk) begin
      if (s_we0) s_mem0[s_addr0] <= s_data0;
      s_rd0 <= s_mem0[s_addr0];
      if (load_l) begin
         for (int x = 0; x < 4; x++) l_mem0[x] <= key_l[x][31:0];
      end else if (l_we0) begin
         l_mem0[l_addr0] <= l_data0;
      end
      l_rd0 <= l_mem0[l_addr0];
      if (s_we1) s_mem1[s_addr1] <= s_data1;
      s_rd1 <= s_mem1[s_addr1];
      if (load_l) begin
         for (int x = 0; x < 2; x++) l_mem1[x] <= key_l[x][15:0];
      end else if (l_we1) begin
         l_mem1[l_addr1] <= l_data1;
      end
      l_rd1 <= l_mem1[l_addr1];
   end

   // view of the engine currently under test
   logic        s_we_m, l_we_m, done_m, busy_m;
   logic [63:0] s_addr_m, s_data_m, l_addr_m, l_data_m;
   always_comb begin
      if (sel) begin
         s_we_m = s_we1; l_we_m = l_we1; done_m = done1; busy_m = busy1;
         s_addr_m = 64'(s_addr1); s_data_m = 64'(s_data1);
         l_addr_m = 64'(l_addr1); l_data_m = 64'(l_data1);
      end else begin
         s_we_m = s_we0; l_we_m = l_we0; done_m = done0; busy_m = busy0;
         s_addr_m = 64'(s_addr0); s_data_m = 64'(s_data0);
         l_addr_m = 64'(l_addr0); l_data_m = 64'(l_data0);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] rotl_m(input logic [63:0] x, input int amt, input int w);
      logic [63:0] m;
      logic [63:0] v;
      m = (64'd1 << w) - 64'd1;
      v = x & m;
      if (amt == 0) return v;
      return ((v << amt) | (v >> (w - amt))) & m;
   endfunction

   // scoreboard monitor: every DUT write must match the next expected write
   always @(negedge clk) begin
      wr_t e;
      if (!rst) begin
         if (s_we_m) begin
            s_wr_cnt++;
            s_log.push_back(s_data_m);
            check_eq("s_pending", 64'(s_exp.size() > 0), 64'd1);
            if (s_exp.size() > 0) begin
               e = s_exp.pop_front();
               check_eq("s_addr", s_addr_m, 64'(e.addr));
               check_eq("s_data", s_data_m, e.data);
            end
         end
         if (l_we_m) begin
            l_wr_cnt++;
            l_log.push_back(l_data_m);
            check_eq("l_pending", 64'(l_exp.size() > 0), 64'd1);
            if (l_exp.size() > 0) begin
               e = l_exp.pop_front();
               check_eq("l_addr", l_addr_m, 64'(e.addr));
               check_eq("l_data", l_data_m, e.data);
            end
         end
      end
   end

   // reference schedule: pushes expected writes and records the final S table
   task automatic push_schedule(input int w, input int t, input int c,
                                input logic [63:0] p, input logic [63:0] q, input int n);
      logic [63:0] m, a, b;
      logic [63:0] s_m [0:31];
      logic [63:0] l_m [0:3];
      int ii, jj;
      wr_t e;
      m = (64'd1 << w) - 64'd1;
      for (int x = 0; x < t; x++) begin
         s_m[x] = (p + 64'(x) * q) & m;
         e.addr = 8'(x); e.data = s_m[x];
         s_exp.push_back(e);
      end
      for (int x = 0; x < c; x++) l_m[x] = key_l[x] & m;
      a = 64'd0; b = 64'd0; ii = 0; jj = 0;
      for (int kk = 0; kk < n; kk++) begin
         a = rotl_m(s_m[ii] + a + b, 3, w);
         s_m[ii] = a;
         e.addr = 8'(ii); e.data = a;
         s_exp.push_back(e);
         b = rotl_m(l_m[jj] + a + b, int'((a + b) % 64'(w)), w);
         l_m[jj] = b;
         e.addr = 8'(jj); e.data = b;
         l_exp.push_back(e);
         ii = (ii + 1) % t;
         jj = (jj + 1) % c;
      end
      for (int x = 0; x < t; x++) s_model[x] = s_m[x];
   endtask

   task automatic set_start(input logic v);
      if (sel) start1 = v;
      else start0 = v;
   endtask

   // load L, arm the scoreboard, then pulse iStart for one clock
   task automatic begin_run(input bit s, output int t, output int n);
      int w, c;
      logic [63:0] p, q;
      sel = s;
      if (s) begin
         w = 16; t = 18; c = 2; p = 64'hB7E1; q = 64'h9E37;
      end else begin
         w = 32; t = 26; c = 4; p = 64'hB7E15163; q = 64'h9E3779B9;
      end
      n = MIX ? 3 * ((t > c) ? t : c) : 0;
      @(negedge clk); load_l = 1'b1;
      @(negedge clk); load_l = 1'b0;
      s_exp.delete(); l_exp.delete(); s_log.delete(); l_log.delete();
      s_wr_cnt = 0; l_wr_cnt = 0;
      push_schedule(w, t, c, p, q, n);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
   endtask

   // full schedule; poke_at>0 re-pulses iStart that many cycles after accept
   task automatic run_sched(input bit s, input int poke_at);
      int t, n, cyc;
      begin_run(s, t, n);
      for (cyc = 1; cyc <= t + 4 * n + 16; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) begin
            check_eq("busy_set", 64'(busy_m), 64'd1);
            check_eq("done_clr", 64'(done_m), 64'd0);
         end
         set_start(cyc == poke_at);
         if (done_m) break;
      end
      set_start(1'b0);
      check_eq("latency", 64'(cyc), 64'(t + 4 * n));
      check_eq("busy_end", 64'(busy_m), 64'd0);
      check_eq("s_writes", 64'(s_wr_cnt), 64'(t + n));
      check_eq("l_writes", 64'(l_wr_cnt), 64'(n));
      check_eq("s_left", 64'(s_exp.size()), 64'd0);
      check_eq("l_left", 64'(l_exp.size()), 64'd0);
      for (int x = 0; x < t; x++)
         check_eq("s_final", sel ? 64'(s_mem1[x]) : 64'(s_mem0[x]), s_model[x]);
   endtask

   task automatic check_idle(input string tag);
      check_eq(tag, 64'({busy0, done0, s_we0, l_we0}), 64'd0);
      check_eq(tag, 64'({s_addr0, l_addr0}), 64'd0);
      check_eq(tag, 64'(s_data0), 64'd0);
      check_eq(tag, 64'(l_data0), 64'd0);
   endtask

   // start a run, hit reset once the target S write has appeared
   task automatic reset_mid_run(input int target);
      int t, n;
      begin_run(1'b0, t, n);
      for (int x = 0; x < t + 4 * n + 16; x++) begin
         @(negedge clk); #1;
         if (s_wr_cnt >= target) break;
      end
      check_eq("abort_point", 64'(s_wr_cnt), 64'(target));
      rst = 1'b1;
      #1;
      check_idle("abort_rst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      s_exp.delete(); l_exp.delete();
   endtask

   initial begin
      logic [31:0] e25;
      for (int x = 0; x < 4; x++) key_l[x] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      check_eq("reset16", 64'({busy1, done1, s_we1, l_we1, s_addr1, l_addr1}), 64'd0);
      check_eq("reset16_data", 64'({s_data1, l_data1}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // all-zero key
      run_sched(1'b0, 0);
      e25 = 32'hB7E15163 + 32'd25 * 32'h9E3779B9;
      check_eq("s0_pw", s_log[0], 64'hB7E15163);
      check_eq("s1", s_log[1], 64'h5618CB1C);
      check_eq("s2", s_log[2], 64'hF45044D5);
      check_eq("s25", s_log[25], 64'(e25));
`ifdef S_MIX_EN
      check_eq("mix_first_s", s_log[26], 64'hBF0A8B1D);
      check_eq("mix_first_l", l_log[0], 64'hB7E15163);
`else
      check_eq("l_tied", 64'({l_we0, l_addr0, l_data0}), 64'd0);
`endif
      repeat (3) @(posedge clk);
      #1;
      check_eq("done_sticky", 64'(done0), 64'd1);

      // random 16-byte key, restart from DONE, extra iStart during INIT
      for (int x = 0; x < 4; x++) key_l[x] = 64'($urandom);
      run_sched(1'b0, 5);
      check_eq("restart_s0", s_log[0], 64'hB7E15163);

      // abort mid-run, then a clean full schedule
      reset_mid_run(MIX ? 26 + 41 : 10);
      for (int x = 0; x < 4; x++) key_l[x] = 64'($urandom);
      run_sched(1'b0, 0);

      // 16-bit word engine
      for (int x = 0; x < 4; x++) key_l[x] = 64'($urandom);
      run_sched(1'b1, 0);
      check_eq("w16_s1", s_log[1], 64'h5618);

      $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
      $finish;
   end

endmodule
